// File: rtl/vend_pkg.sv
// Shared types, constants and coin helpers for the vending purchase sequencer.
package vend_pkg;

    localparam int NPROD = 4;
    localparam int CW    = 7;
    localparam int SW    = 4;

    localparam logic [SW-1:0] RSTOCK = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        PAYOUT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    localparam logic [CW-1:0] NICKEL_VAL  = 7'd5;
    localparam logic [CW-1:0] DIME_VAL    = 7'd10;
    localparam logic [CW-1:0] QUARTER_VAL = 7'd25;

    localparam logic [CW-1:0] PRICE [NPROD] = '{7'd5, 7'd10, 7'd15, 7'd30};

    function automatic logic [CW-1:0] coin_value(input logic [1:0] c);
        logic [CW-1:0] v;
        case (c)
            COIN_NICKEL:  v = NICKEL_VAL;
            COIN_DIME:    v = DIME_VAL;
            COIN_QUARTER: v = QUARTER_VAL;
            default:      v = 7'd0;
        endcase
        return v;
    endfunction

    // Largest coin that does not exceed the remaining credit.
    function automatic logic [1:0] greedy_coin(input logic [CW-1:0] m);
        logic [1:0] c;
        if (m >= QUARTER_VAL) begin
            c = COIN_QUARTER;
        end else if (m >= DIME_VAL) begin
            c = COIN_DIME;
        end else if (m >= NICKEL_VAL) begin
            c = COIN_NICKEL;
        end else begin
            c = COIN_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/vend_prio_arb.sv
// Fixed-priority (slot 0 highest) grant over the Buy lines; a slot is only
// eligible once its request has been seen low during an IDLE cycle.
module vend_prio_arb
    import vend_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idle,
    input  logic [NPROD-1:0] req,
    output logic [NPROD-1:0] grant,
    output logic [1:0]       grant_idx,
    output logic             grant_valid
);

    logic [NPROD-1:0] armed_r;
    logic [NPROD-1:0] eligible_s;

    // Re-arm tracking: a held request disarms itself after one IDLE look.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 4'b0000;
        end else if (idle) begin
            armed_r <= ~req;
        end else begin
            armed_r <= armed_r;
        end
    end

    // Lowest-index eligible request wins.
    always_comb begin
        eligible_s  = req & armed_r;
        grant       = 4'b0000;
        grant_idx   = 2'd0;
        grant_valid = 1'b0;
        if (eligible_s[0]) begin
            grant = 4'b0001; grant_idx = 2'd0; grant_valid = 1'b1;
        end else if (eligible_s[1]) begin
            grant = 4'b0010; grant_idx = 2'd1; grant_valid = 1'b1;
        end else if (eligible_s[2]) begin
            grant = 4'b0100; grant_idx = 2'd2; grant_valid = 1'b1;
        end else if (eligible_s[3]) begin
            grant = 4'b1000; grant_idx = 2'd3; grant_valid = 1'b1;
        end else begin
            grant = 4'b0000; grant_idx = 2'd0; grant_valid = 1'b0;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Vending purchase sequencer: coin credit, product grant with credit/stock
// check, one-cycle vend pulse, and greedy coin payout of remaining credit.
module vend_controller
    import vend_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          Coin,
    input  logic [NPROD-1:0]    Buy,
    input  logic                Return,
    input  logic                Restock,
    output logic [CW-1:0]       Money,
    output logic [NPROD*SW-1:0] Stock,
    output logic [NPROD-1:0]    Vending,
    output logic [1:0]          CoinOut,
    output logic                Busy,
    output logic                Reject
);

    state_t           state_r;
    logic [CW-1:0]    money_r;
    logic [SW-1:0]    stock_r [NPROD];
    logic [1:0]       slot_r;
    logic [NPROD-1:0] vending_r;
    logic [1:0]       coin_out_r;
    logic             busy_r;
    logic             reject_r;

    logic [NPROD-1:0] grant_s;
    logic [1:0]       grant_idx_s;
    logic             grant_valid_s;

    logic [CW-1:0]    coin_val_s;
    logic [CW:0]      credit_sum_s;
    logic             coin_in_s;
    logic             coin_over_s;
    logic [CW-1:0]    money_credit_s;
    logic             grant_ok_s;
    logic [CW-1:0]    pay_val_s;
    logic [CW-1:0]    money_after_pay_s;
    logic [CW-1:0]    vend_money_s;

    vend_prio_arb u_arb (
        .clk         (Clk),
        .rst_n       (Reset),
        .idle        (state_r == IDLE),
        .req         (Buy),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Credit, price/stock check and payout arithmetic; price check uses pre-coin credit.
    always_comb begin
        coin_val_s   = coin_value(Coin);
        coin_in_s    = (Coin != COIN_NONE);
        credit_sum_s = {1'b0, money_r} + {1'b0, coin_val_s};
        coin_over_s  = credit_sum_s[CW];
        if (coin_in_s && !coin_over_s) begin
            money_credit_s = credit_sum_s[CW-1:0];
        end else begin
            money_credit_s = money_r;
        end
        grant_ok_s = grant_valid_s && (money_r >= PRICE[grant_idx_s])
                     && (stock_r[grant_idx_s] != 4'd0);
        pay_val_s         = coin_value(greedy_coin(money_r));
        money_after_pay_s = money_r - pay_val_s;
        vend_money_s      = money_r - PRICE[slot_r];
    end

    // Main FSM with credit register, stock array and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= IDLE;
            money_r    <= 7'd0;
            slot_r     <= 2'd0;
            vending_r  <= 4'b0000;
            coin_out_r <= COIN_NONE;
            busy_r     <= 1'b0;
            reject_r   <= 1'b0;
            for (int i = 0; i < NPROD; i++) begin
                stock_r[i] <= RSTOCK;
            end
        end else begin
            vending_r <= 4'b0000;
            case (state_r)
                IDLE: begin
                    money_r  <= money_credit_s;
                    reject_r <= (coin_in_s && coin_over_s) || (grant_valid_s && !grant_ok_s);
                    if (Buy != 4'b0000) begin
                        if (grant_ok_s) begin
                            state_r   <= VEND;
                            slot_r    <= grant_idx_s;
                            vending_r <= grant_s;
                            busy_r    <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        if (Restock) begin
                            for (int i = 0; i < NPROD; i++) begin
                                stock_r[i] <= RSTOCK;
                            end
                        end else begin
                            slot_r <= slot_r;
                        end
                        if (Return && (money_credit_s != 7'd0)) begin
                            state_r    <= PAYOUT;
                            busy_r     <= 1'b1;
                            coin_out_r <= greedy_coin(money_credit_s);
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                VEND: begin
                    reject_r        <= coin_in_s;
                    money_r         <= vend_money_s;
                    stock_r[slot_r] <= stock_r[slot_r] - 4'd1;
                    state_r         <= IDLE;
                    busy_r          <= 1'b0;
                end
                PAYOUT: begin
                    reject_r <= coin_in_s;
                    // Leave once the remainder can no longer buy a nickel; any residue is dropped.
                    if (money_after_pay_s < NICKEL_VAL) begin
                        state_r    <= IDLE;
                        money_r    <= 7'd0;
                        coin_out_r <= COIN_NONE;
                        busy_r     <= 1'b0;
                    end else begin
                        money_r    <= money_after_pay_s;
                        coin_out_r <= greedy_coin(money_after_pay_s);
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    money_r    <= 7'd0;
                    coin_out_r <= COIN_NONE;
                    busy_r     <= 1'b0;
                    reject_r   <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the stock array onto the output bus.
    always_comb begin
        Stock = {(NPROD*SW){1'b0}};
        for (int i = 0; i < NPROD; i++) begin
            Stock[SW*i +: SW] = stock_r[i];
        end
    end

    assign Money   = money_r;
    assign Vending = vending_r;
    assign CoinOut = coin_out_r;
    assign Busy    = busy_r;
    assign Reject  = reject_r;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random
// traffic, all checked against a transaction-level purchase/payout model.
module tb_vend_controller;

    logic        Clk;
    logic        Reset;
    logic [1:0]  Coin;
    logic [3:0]  Buy;
    logic        Return;
    logic        Restock;
    logic [6:0]  Money;
    logic [15:0] Stock;
    logic [3:0]  Vending;
    logic [1:0]  CoinOut;
    logic        Busy;
    logic        Reject;

    vend_controller dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Coin    (Coin),
        .Buy     (Buy),
        .Return  (Return),
        .Restock (Restock),
        .Money   (Money),
        .Stock   (Stock),
        .Vending (Vending),
        .CoinOut (CoinOut),
        .Busy    (Busy),
        .Reject  (Reject)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = idle, 1 = vending, 2 = paying out a coin list.
    int m_money;
    int m_stock [4];
    int m_mode;
    int m_slot;
    bit m_released [4];
    int m_queue [$];
    int e_vending, e_coinout, e_busy, e_reject;
    int price_tab [4] = '{5, 10, 15, 30};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int cents(input int c);
        case (c)
            1:       return 5;
            2:       return 10;
            3:       return 25;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_money = 0;
        m_mode  = 0;
        m_slot  = 0;
        m_queue.delete();
        for (int i = 0; i < 4; i++) begin
            m_stock[i]    = 9;
            m_released[i] = 1'b0;
        end
        e_vending = 0; e_coinout = 0; e_busy = 0; e_reject = 0;
    endtask

    task automatic model_step(input logic [1:0] c, input logic [3:0] b, input logic r, input logic rs);
        int credited;
        int pick;
        int rem;
        int cc;
        e_reject  = 0;
        e_vending = 0;
        if (m_mode == 0) begin
            credited = m_money;
            pick     = -1;
            if (c != 2'd0) begin
                if (m_money + cents(c) > 127) e_reject = 1;
                else credited = m_money + cents(c);
            end
            if (b != 4'd0) begin
                for (int i = 0; i < 4; i++) begin
                    if (pick < 0 && b[i] && m_released[i]) pick = i;
                end
                if (pick >= 0) begin
                    if (m_money >= price_tab[pick] && m_stock[pick] > 0) begin
                        m_mode    = 1;
                        m_slot    = pick;
                        e_vending = 1 << pick;
                    end else begin
                        e_reject = 1;
                    end
                end
            end else begin
                if (rs) begin
                    for (int i = 0; i < 4; i++) m_stock[i] = 9;
                end
                if (r && credited > 0) begin
                    rem = credited;
                    while (rem >= 5) begin
                        cc = (rem >= 25) ? 3 : (rem >= 10) ? 2 : 1;
                        m_queue.push_back(cc);
                        rem -= cents(cc);
                    end
                    m_mode = 2;
                end
            end
            for (int i = 0; i < 4; i++) m_released[i] = !b[i];
            m_money = credited;
        end else if (m_mode == 1) begin
            if (c != 2'd0) e_reject = 1;
            m_money -= price_tab[m_slot];
            m_stock[m_slot] -= 1;
            m_mode = 0;
        end else begin
            if (c != 2'd0) e_reject = 1;
            cc = m_queue.pop_front();
            m_money -= cents(cc);
            if (m_queue.size() == 0) begin
                m_mode  = 0;
                m_money = 0;
            end
        end
        e_busy    = (m_mode != 0) ? 1 : 0;
        e_coinout = (m_mode == 2 && m_queue.size() > 0) ? m_queue[0] : 0;
    endtask

    function automatic logic [15:0] exp_stock_bus();
        logic [15:0] s;
        logic [31:0] v;
        s = 16'd0;
        for (int i = 0; i < 4; i++) begin
            v = m_stock[i];
            s[4*i +: 4] = v[3:0];
        end
        return s;
    endfunction

    task automatic check_all();
        check_val("money",   Money,   m_money);
        check_val("stock",   Stock,   exp_stock_bus());
        check_val("vending", Vending, e_vending);
        check_val("coinout", CoinOut, e_coinout);
        check_val("busy",    Busy,    e_busy);
        check_val("reject",  Reject,  e_reject);
    endtask

    // Called at a falling edge: drive, advance the model, check at the next falling edge.
    task automatic run_cycle(input logic [1:0] c, input logic [3:0] b, input logic r, input logic rs);
        Coin = c; Buy = b; Return = r; Restock = rs;
        model_step(c, b, r, rs);
        @(negedge Clk);
        check_all();
    endtask

    initial begin
        logic [31:0] rv;
        logic [1:0]  rc;
        logic [3:0]  rb;
        int guard;

        Reset = 1'b0; Coin = 2'd0; Buy = 4'd0; Return = 1'b0; Restock = 1'b0;
        model_reset();
        @(negedge Clk);
        check_all();
        check_val("rst_stock", Stock, 16'h9999);
        check_val("rst_money", Money, 7'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // Scenario 1: quarter + dime, buy slot 2.
        run_cycle(2'd3, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd2, 4'd0, 1'b0, 1'b0);
        check_val("t1_money35", Money, 7'd35);
        run_cycle(2'd0, 4'b0100, 1'b0, 1'b0);
        check_val("t1_vend", Vending, 4'b0100);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        check_val("t1_money20", Money, 7'd20);
        check_val("t1_stock2", Stock[11:8], 4'd8);
        check_val("t1_vend_off", Vending, 4'd0);

        // Scenario 2: down to 10 cents, then slot 3 refused.
        run_cycle(2'd0, 4'b0010, 1'b0, 1'b0);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        check_val("t2_money10", Money, 7'd10);
        run_cycle(2'd0, 4'b1000, 1'b0, 1'b0);
        check_val("t2_reject", Reject, 1'b1);
        check_val("t2_novend", Vending, 4'd0);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        check_val("t2_reject_pulse", Reject, 1'b0);
        check_val("t2_money_kept", Money, 7'd10);

        // Scenario 3: 40 cents paid out as quarter, dime, nickel.
        run_cycle(2'd3, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd1, 4'd0, 1'b0, 1'b0);
        check_val("t3_money40", Money, 7'd40);
        run_cycle(2'd0, 4'd0, 1'b1, 1'b0);
        check_val("t3_q", CoinOut, 2'd3);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        check_val("t3_d", CoinOut, 2'd2);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        check_val("t3_n", CoinOut, 2'd1);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        check_val("t3_idle", Busy, 1'b0);
        check_val("t3_money0", Money, 7'd0);

        // Scenario 4: saturation at 125 and coin during payout.
        for (int i = 0; i < 5; i++) run_cycle(2'd3, 4'd0, 1'b0, 1'b0);
        check_val("t4_money125", Money, 7'd125);
        run_cycle(2'd1, 4'd0, 1'b0, 1'b0);
        check_val("t4_sat_rej", Reject, 1'b1);
        check_val("t4_sat_money", Money, 7'd125);
        run_cycle(2'd0, 4'd0, 1'b1, 1'b0);
        run_cycle(2'd3, 4'd0, 1'b0, 1'b0);
        check_val("t4_payout_rej", Reject, 1'b1);
        for (int i = 0; i < 5; i++) run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        check_val("t4_drained", Money, 7'd0);

        // Scenario 5: priority and no auto-repeat while Buy is held.
        run_cycle(2'd3, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd1, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd0, 4'b0011, 1'b0, 1'b0);
        check_val("t5_slot0", Vending, 4'b0001);
        run_cycle(2'd0, 4'b0011, 1'b0, 1'b0);
        check_val("t5_money25", Money, 7'd25);
        run_cycle(2'd0, 4'b0011, 1'b0, 1'b0);
        check_val("t5_held", Vending, 4'd0);
        run_cycle(2'd0, 4'b0011, 1'b0, 1'b0);
        check_val("t5_held2", Vending, 4'd0);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd0, 4'b0011, 1'b0, 1'b0);
        check_val("t5_regrant", Vending, 4'b0001);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b0);

        // Scenario 6: empty slot 1, refuse, restock, reset mid-payout.
        guard = 0;
        while (m_stock[1] > 0 && guard < 40) begin
            run_cycle((m_money < 10) ? 2'd2 : 2'd0, 4'd0, 1'b0, 1'b0);
            run_cycle(2'd0, 4'b0010, 1'b0, 1'b0);
            run_cycle(2'd0, 4'd0, 1'b0, 1'b0);
            guard++;
        end
        check_val("t6_stock1_empty", Stock[7:4], 4'd0);
        run_cycle(2'd2, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd0, 4'b0010, 1'b0, 1'b0);
        check_val("t6_empty_rej", Reject, 1'b1);
        check_val("t6_empty_novend", Vending, 4'd0);
        run_cycle(2'd0, 4'd0, 1'b0, 1'b1);
        check_val("t6_restock", Stock[7:4], 4'd9);
        run_cycle(2'd3, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd3, 4'd0, 1'b0, 1'b0);
        run_cycle(2'd0, 4'd0, 1'b1, 1'b0);
        check_val("t6_in_payout", Busy, 1'b1);
        #2 Reset = 1'b0;
        #1 model_reset();
        check_all();
        check_val("t6_rst_busy", Busy, 1'b0);
        check_val("t6_rst_coin", CoinOut, 2'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // Random traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            rv = $urandom;
            rc = (rv[0]) ? rv[2:1] : 2'd0;
            rb = (rv[4:3] == 2'd0) ? rv[8:5] : 4'd0;
            run_cycle(rc, rb, (rv[12:9] == 4'd0), (rv[17:13] == 5'd0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
